// File: rtl/slot_pkg.sv
// rtl/slot_pkg.sv - shared state encoding, digit width and digit-wrap helper for the reel display
package slot_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SPIN     = 3'd1,
    S_STOPPING = 3'd2,
    S_CHECK    = 3'd3,
    S_WIN      = 3'd4,
    S_LOSE     = 3'd5
  } state_t;

  function automatic logic [DIGIT_W-1:0] digit_inc(input logic [DIGIT_W-1:0] d);
    return (d >= MAX_DIGIT) ? '0 : d + 1'b1;
  endfunction

endpackage

// File: rtl/reel_counter.sv
// rtl/reel_counter.sv - one reel: prescaler that advances a decimal digit every DIV enabled cycles
module reel_counter
  import slot_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_pre,
  input  logic               run,
  output logic [DIGIT_W-1:0] digit
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] pre;

  // With run low the prescaler holds too; it is always restarted by clear_pre before the next spin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre   <= '0;
      digit <= '0;
    end else if (clear_pre) begin
      pre <= '0;
    end else if (run) begin
      if (pre == PW'(DIV - 1)) begin
        pre   <= '0;
        digit <= digit_inc(digit);
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

endmodule

// File: rtl/reel_sequencer.sv
// rtl/reel_sequencer.sv - three-reel slot controller: button sync, spin, staggered stop, match check, buzzer
module reel_sequencer
  import slot_pkg::*;
#(
  parameter int DIV0        = 1_000_000,
  parameter int DIV1        = 2_000_000,
  parameter int DIV2        = 3_000_000,
  parameter int STAGGER     = 500_000,
  parameter int BUZZ_CYCLES = 25_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_stop,
  output logic [DIGIT_W-1:0] digit0,
  output logic [DIGIT_W-1:0] digit1,
  output logic [DIGIT_W-1:0] digit2,
  output logic               buzzer,
  output logic               win,
  output logic               lose,
  output logic [2:0]         state_o
);

  localparam int SW = $clog2(2 * STAGGER) + 1;
  localparam int BW = $clog2(BUZZ_CYCLES) + 1;

  state_t        state;
  logic          s1, s2, s3;
  logic          press;
  logic          clear_pre;
  logic          run0, run1, run2;
  logic [SW-1:0] stag_cnt;
  logic [BW-1:0] buzz_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= start_stop;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign press     = s2 & ~s3;
  assign clear_pre = (state == S_IDLE) && press;

  // Reel 0 freezes on the stop edge itself; reels 1 and 2 drop out at the stagger marks.
  assign run0 = (state == S_SPIN) && !press;
  assign run1 = (state == S_SPIN) ||
                ((state == S_STOPPING) && (stag_cnt < SW'(STAGGER - 1)));
  assign run2 = (state == S_SPIN) ||
                ((state == S_STOPPING) && (stag_cnt < SW'(2 * STAGGER - 1)));

  reel_counter #(.DIV(DIV0)) u_reel0 (
    .clk(clk), .reset(reset), .clear_pre(clear_pre), .run(run0), .digit(digit0)
  );
  reel_counter #(.DIV(DIV1)) u_reel1 (
    .clk(clk), .reset(reset), .clear_pre(clear_pre), .run(run1), .digit(digit1)
  );
  reel_counter #(.DIV(DIV2)) u_reel2 (
    .clk(clk), .reset(reset), .clear_pre(clear_pre), .run(run2), .digit(digit2)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      stag_cnt <= '0;
      buzz_cnt <= '0;
      buzzer   <= 1'b0;
      win      <= 1'b0;
      lose     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (press) state <= S_SPIN;
        end
        S_SPIN: begin
          if (press) begin
            state    <= S_STOPPING;
            stag_cnt <= '0;
          end
        end
        S_STOPPING: begin
          stag_cnt <= stag_cnt + 1'b1;
          if (stag_cnt == SW'(2 * STAGGER - 1)) state <= S_CHECK;
        end
        S_CHECK: begin
          buzz_cnt <= '0;
          if ((digit0 == digit1) && (digit1 == digit2)) begin
            state  <= S_WIN;
            win    <= 1'b1;
            buzzer <= 1'b1;
          end else begin
            state <= S_LOSE;
            lose  <= 1'b1;
          end
        end
        S_WIN: begin
          if (press) begin
            state  <= S_IDLE;
            win    <= 1'b0;
            buzzer <= 1'b0;
          end else if (buzzer) begin
            if (buzz_cnt == BW'(BUZZ_CYCLES - 1)) buzzer <= 1'b0;
            else buzz_cnt <= buzz_cnt + 1'b1;
          end
        end
        S_LOSE: begin
          if (press) begin
            state <= S_IDLE;
            lose  <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          buzzer <= 1'b0;
          win    <= 1'b0;
          lose   <= 1'b0;
        end
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_reel_sequencer.sv
// tb/tb_reel_sequencer.sv - randomized games on two parameter sets, checked cycle by cycle against a timeline model
module tb_reel_sequencer;

  localparam int BIG = 1 << 30;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_a, btn_b;
  logic [3:0] a_d0, a_d1, a_d2, b_d0, b_d1, b_d2;
  logic       a_bz, a_win, a_lose, b_bz, b_win, b_lose;
  logic [2:0] a_st, b_st;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  // model: which bench DUT is live, its parameters, digits at game start and event edges
  int sel;
  int dv[3];
  int stg, bz;
  int held[3];
  int ts, tp, tx;

  reel_sequencer #(.DIV0(2), .DIV1(3), .DIV2(5), .STAGGER(4), .BUZZ_CYCLES(6)) dut_a (
    .clk(clk), .reset(reset), .start_stop(btn_a),
    .digit0(a_d0), .digit1(a_d1), .digit2(a_d2),
    .buzzer(a_bz), .win(a_win), .lose(a_lose), .state_o(a_st)
  );

  reel_sequencer #(.DIV0(16), .DIV1(16), .DIV2(16), .STAGGER(2), .BUZZ_CYCLES(6)) dut_b (
    .clk(clk), .reset(reset), .start_stop(btn_b),
    .digit0(b_d0), .digit1(b_d1), .digit2(b_d2),
    .buzzer(b_bz), .win(b_win), .lose(b_lose), .state_o(b_st)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  // Digit after edge t: start digit plus ticks at edges ts+k*DIV that precede the reel's freeze edge.
  function automatic int exp_digit(input int i, input int t);
    int frz, last;
    if (t < ts) return held[i];
    frz  = (tp == BIG) ? BIG : tp + i * stg;
    last = (t < frz - 1) ? t : frz - 1;
    return (held[i] + (last - ts) / dv[i]) % 10;
  endfunction

  function automatic int exp_state(input int t);
    int te;
    if (t < ts || t >= tx) return 0;
    if (t < tp) return 1;
    te = tp + 2 * stg;
    if (t < te) return 2;
    if (t == te) return 3;
    return (exp_digit(0, te) == exp_digit(1, te) && exp_digit(1, te) == exp_digit(2, te)) ? 4 : 5;
  endfunction

  task automatic check_cycle();
    int t, st;
    int g[7];
    t  = cyc;
    st = exp_state(t);
    if (sel == 0) begin
      g[0] = int'(a_d0); g[1] = int'(a_d1); g[2] = int'(a_d2); g[3] = int'(a_st);
      g[4] = int'(a_win); g[5] = int'(a_lose); g[6] = int'(a_bz);
    end else begin
      g[0] = int'(b_d0); g[1] = int'(b_d1); g[2] = int'(b_d2); g[3] = int'(b_st);
      g[4] = int'(b_win); g[5] = int'(b_lose); g[6] = int'(b_bz);
    end
    check("digit0", g[0], exp_digit(0, t));
    check("digit1", g[1], exp_digit(1, t));
    check("digit2", g[2], exp_digit(2, t));
    check("state", g[3], st);
    check("win", g[4], (st == 4) ? 1 : 0);
    check("lose", g[5], (st == 5) ? 1 : 0);
    check("buzzer", g[6], (st == 4 && t <= tp + 2 * stg + bz) ? 1 : 0);
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_cycle();
    end
  endtask

  task automatic step_until(input int target);
    while (cyc < target) step(1);
  endtask

  task automatic set_btn(input logic v);
    if (sel == 0) btn_a = v;
    else btn_b = v;
  endtask

  task automatic clear_model();
    held = '{0, 0, 0};
    ts = BIG; tp = BIG; tx = BIG;
  endtask

  task automatic use_dut(input int s);
    sel = s;
    if (s == 0) begin
      dv = '{2, 3, 5};
      stg = 4;
    end else begin
      dv = '{16, 16, 16};
      stg = 2;
    end
    bz = 6;
    clear_model();
  endtask

  task automatic begin_game();
    int fin[3];
    if (ts != BIG) begin
      for (int i = 0; i < 3; i++) fin[i] = exp_digit(i, tp + 2 * stg);
      held = fin;
    end
    ts = BIG; tp = BIG; tx = BIG;
  endtask

  // start press, stop press so that STOPPING begins stop_at edges after SPIN entry, optional ignored
  // press during STOPPING, then exit press taking effect ed edges after the first WIN/LOSE edge
  task automatic play_game(input int hold, input int stop_at, input bit extra, input int ed);
    int tw;
    begin_game();
    set_btn(1'b1);
    ts = cyc + 3;
    step(hold);
    set_btn(1'b0);
    step_until(ts + stop_at - 3);
    set_btn(1'b1);
    tp = cyc + 3;
    step(2);
    set_btn(1'b0);
    if (extra) begin
      step(2);
      set_btn(1'b1);
      step(2);
      set_btn(1'b0);
    end
    tw = tp + 2 * stg + 1;
    step_until(tw + ed - 3);
    set_btn(1'b1);
    tx = cyc + 3;
    step(2);
    set_btn(1'b0);
    step(4);
  endtask

  initial begin
    int hold;
    btn_a = 1'b1;
    btn_b = 1'b0;
    reset = 1'b0;
    use_dut(0);
    #1 reset = 1'b1;
    #1;
    check("por_state", int'(a_st), 0);
    check("por_digits", int'({a_d0, a_d1, a_d2}), 0);
    check("por_flags", int'({a_bz, a_win, a_lose}), 0);
    step(4);
    btn_a = 1'b0;
    step(2);
    reset = 1'b0;
    step(3);

    for (int g = 0; g < 6; g++) begin
      hold = $urandom_range(3, 8);
      play_game(hold, hold + 1 + $urandom_range(0, 40), 1'($urandom_range(0, 1)),
                $urandom_range(1, 10));
    end

    begin_game();
    set_btn(1'b1);
    ts = cyc + 3;
    step(3);
    set_btn(1'b0);
    step_until(ts + 10 + $urandom_range(0, 9));
    set_btn(1'b1);
    tp = cyc + 3;
    step(2);
    set_btn(1'b0);
    step_until(tp + 2);
    #2 reset = 1'b1;
    #1;
    check("rst_state", int'(a_st), 0);
    check("rst_d0", int'(a_d0), 0);
    check("rst_d1", int'(a_d1), 0);
    check("rst_d2", int'(a_d2), 0);
    check("rst_flags", int'({a_bz, a_win, a_lose}), 0);
    clear_model();
    step(2);
    reset = 1'b0;
    step(3);
    play_game(4, 5 + $urandom_range(0, 20), 1'b0, 2);

    use_dut(1);
    step(3);
    play_game(3, $urandom_range(49, 60), 1'b0, 9);
    check("b_hold0", int'(b_d0), 3);
    check("b_hold1", int'(b_d1), 3);
    check("b_hold2", int'(b_d2), 3);
    play_game(4, $urandom_range(49, 60), 1'b0, 3);
    check("b_again0", int'(b_d0), 6);
    check("b_again_state", int'(b_st), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
